// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and the Sysbus DRAM port.
// The master modport is the environment side (caches and memory).
// The slave modport is the arbiter side.
interface mem_bus_arbiter_if #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13
);
    // Client side, two clients packed side by side (client i in slice i)
    logic [1:0]                  c_reqcyc;
    logic [1:0]                  c_reqack;
    logic [2*BUS_DATA_WIDTH-1:0] c_req;
    logic [2*BUS_TAG_WIDTH-1:0]  c_reqtag;
    logic [1:0]                  c_respcyc;
    logic [1:0]                  c_respack;
    logic [BUS_DATA_WIDTH-1:0]   c_resp;
    logic [BUS_TAG_WIDTH-1:0]    c_resptag;

    // Memory side
    logic                        m_reqcyc;
    logic                        m_reqack;
    logic [BUS_DATA_WIDTH-1:0]   m_req;
    logic [BUS_TAG_WIDTH-1:0]    m_reqtag;
    logic                        m_respcyc;
    logic                        m_respack;
    logic [BUS_DATA_WIDTH-1:0]   m_resp;
    logic [BUS_TAG_WIDTH-1:0]    m_resptag;

    modport master (
        output c_reqcyc, c_req, c_reqtag, c_respack,
        output m_reqack, m_respcyc, m_resp, m_resptag,
        input  c_reqack, c_respcyc, c_resp, c_resptag,
        input  m_reqcyc, m_req, m_reqtag, m_respack
    );

    modport slave (
        input  c_reqcyc, c_req, c_reqtag, c_respack,
        input  m_reqack, m_respcyc, m_resp, m_resptag,
        output c_reqack, c_respcyc, c_resp, c_resptag,
        output m_reqcyc, m_req, m_reqtag, m_respack
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one DRAM port between the I-cache (client 0)
// and the D-cache (client 1); a grant is held for a whole response burst.
module mem_bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned BURST_BEATS    = 8
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);
    localparam int unsigned DW     = BUS_DATA_WIDTH;
    localparam int unsigned TW     = BUS_TAG_WIDTH;
    localparam int unsigned BEAT_W = $clog2(BURST_BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [DW-1:0]       addr_q, addr_d;
    logic [TW-1:0]       tag_q, tag_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic                win_c;
    logic [1:0]          reqack_c;
    logic [1:0]          respcyc_c;
    logic                respack_c;

    // Round-robin pick: a lone requester wins, a tie goes to the client not served last
    always_comb begin
        unique case (bus.c_reqcyc)
            2'b01:   win_c = 1'b0;
            2'b10:   win_c = 1'b1;
            2'b11:   win_c = ~last_grant_q;
            default: win_c = 1'b0;
        endcase
    end

    // State register with synchronous reset; reset also aborts an in-flight burst
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            tag_q        <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            beat_q       <= beat_d;
        end
    end

    // Next-state and handshake steering
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        tag_d        = tag_q;
        beat_d       = beat_q;
        reqack_c     = 2'b00;
        respcyc_c    = 2'b00;
        respack_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|bus.c_reqcyc) begin
                    grant_d = win_c;
                    addr_d  = win_c ? bus.c_req[2*DW-1:DW]    : bus.c_req[DW-1:0];
                    tag_d   = win_c ? bus.c_reqtag[2*TW-1:TW] : bus.c_reqtag[TW-1:0];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.m_reqack) begin
                    reqack_c[grant_q] = 1'b1;
                    beat_d            = '0;
                    state_d           = RESP;
                end
            end
            RESP: begin
                respcyc_c[grant_q] = bus.m_respcyc;
                respack_c          = bus.m_respcyc & bus.c_respack[grant_q];
                if (respack_c) begin
                    if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
                        beat_d       = '0;
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory request side comes straight from the latched request registers
    assign bus.m_reqcyc  = (state_q == REQ);
    assign bus.m_req     = (state_q == REQ) ? addr_q : '0;
    assign bus.m_reqtag  = (state_q == REQ) ? tag_q  : '0;
    assign bus.m_respack = respack_c;

    // Client side: acks and response valid are steered to the granted client only
    assign bus.c_reqack  = reqack_c;
    assign bus.c_respcyc = respcyc_c;
    assign bus.c_resp    = (state_q == RESP) ? bus.m_resp    : '0;
    assign bus.c_resptag = (state_q == RESP) ? bus.m_resptag : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected requests and
// beats into queues; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;
    localparam int unsigned DW    = 64;
    localparam int unsigned TW    = 13;
    localparam int unsigned BEATS = 8;

    typedef struct packed {
        logic [1:0]    owner;
        logic [DW-1:0] addr;
        logic [TW-1:0] tag;
    } req_exp_t;

    typedef struct packed {
        logic [1:0]    owner;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } beat_exp_t;

    logic clk;
    logic reset;

    mem_bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

    mem_bus_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .BURST_BEATS    (BEATS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    req_exp_t  req_q[$];
    beat_exp_t beat_q[$];

    // Check requests from stimulus to monitor
    bit chk_idle;
    bit chk_quiet;
    bit chk_noack;
    bit chk_reqnow;
    bit done;
    int n_timeouts;

    int n_checks;
    int n_fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: samples mid-cycle, away from the rising edge
    always @(negedge clk) begin
        req_exp_t  r;
        beat_exp_t b;
        if (chk_idle) begin
            chk("idle_ctrl", 64'({bus.c_reqack, bus.c_respcyc, bus.m_reqcyc, bus.m_respack}), 64'd0);
            chk("idle_m_req", bus.m_req, 64'd0);
            chk("idle_m_reqtag", 64'(bus.m_reqtag), 64'd0);
        end
        if (chk_quiet) begin
            chk("spurious_m_respack", 64'(bus.m_respack), 64'd0);
            chk("spurious_c_respcyc", 64'(bus.c_respcyc), 64'd0);
        end
        if (chk_noack) begin
            chk("stall_m_respack", 64'(bus.m_respack), 64'd0);
        end
        if (chk_reqnow) begin
            chk("req_latency_m_reqcyc", 64'(bus.m_reqcyc), 64'd1);
        end
        if (bus.m_reqcyc && bus.m_reqack) begin
            if (req_q.size() == 0) begin
                chk("unexpected_request", 64'd1, 64'd0);
            end else begin
                r = req_q.pop_front();
                chk("grant_c_reqack", 64'(bus.c_reqack), 64'(r.owner));
                chk("m_req", bus.m_req, r.addr);
                chk("m_reqtag", 64'(bus.m_reqtag), 64'(r.tag));
            end
        end else if (bus.c_reqack != 2'b00) begin
            chk("stray_c_reqack", 64'(bus.c_reqack), 64'd0);
        end
        if (bus.c_respcyc == 2'b11) begin
            chk("c_respcyc_overlap", 64'(bus.c_respcyc), 64'd0);
        end
        if (bus.m_respack) begin
            if (beat_q.size() == 0) begin
                chk("extra_beat", 64'd1, 64'd0);
            end else begin
                b = beat_q.pop_front();
                chk("beat_m_respcyc", 64'(bus.m_respcyc), 64'd1);
                chk("beat_c_respcyc", 64'(bus.c_respcyc), 64'(b.owner));
                chk("beat_c_resp", bus.c_resp, b.data);
                chk("beat_c_resptag", 64'(bus.c_resptag), 64'(b.tag));
            end
        end
        if (done) begin
            chk("pending_requests", 64'(req_q.size()), 64'd0);
            chk("pending_beats", 64'(beat_q.size()), 64'd0);
            chk("wait_timeouts", 64'(n_timeouts), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
            $finish;
        end
    end

    // Advance one cycle; inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        chk_reqnow = 1'b0;
    endtask

    task automatic set_req(input int cl, input logic [DW-1:0] addr, input logic [TW-1:0] tag);
        if (cl == 0) begin
            bus.c_req[DW-1:0]    = addr;
            bus.c_reqtag[TW-1:0] = tag;
        end else begin
            bus.c_req[2*DW-1:DW]    = addr;
            bus.c_reqtag[2*TW-1:TW] = tag;
        end
        bus.c_reqcyc[cl] = 1'b1;
    endtask

    // One transaction as seen by the memory model; expects DUT already in REQ
    task automatic run_txn(input int cl, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                           input logic [DW-1:0] base, input int ack_dly,
                           input int stall_at, input int stall_len, input int abort_at,
                           input logic [1:0] drop);
        int t;
        req_q.push_back('{owner: (cl == 0) ? 2'b01 : 2'b10, addr: addr, tag: tag});
        chk_reqnow = 1'b1;
        t = 0;
        while (!bus.m_reqcyc && t < 20) begin
            step();
            t++;
        end
        if (!bus.m_reqcyc) begin
            n_timeouts++;
            return;
        end
        // Memory stalls the request ack; responses arriving now must be ignored
        for (int i = 0; i < ack_dly; i++) begin
            bus.m_respcyc = 1'b1;
            bus.m_resp    = 64'hBAD0_0000 + 64'(i);
            chk_quiet     = 1'b1;
            step();
        end
        chk_quiet     = 1'b0;
        bus.m_respcyc = 1'b0;
        bus.m_reqack  = 1'b1;
        step();
        bus.m_reqack  = 1'b0;
        bus.c_reqcyc  = bus.c_reqcyc & ~drop;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (i == abort_at) begin
                bus.m_respcyc = 1'b0;
                reset         = 1'b1;
                step();
                reset         = 1'b0;
                bus.m_respcyc = 1'b1;
                bus.m_resp    = base + 64'(i);
                chk_idle      = 1'b1;
                step();
                chk_idle      = 1'b0;
                bus.m_respcyc = 1'b0;
                return;
            end
            bus.m_respcyc = 1'b1;
            bus.m_resp    = base + 64'(i);
            bus.m_resptag = tag;
            if (i == stall_at) begin
                bus.c_respack[cl] = 1'b0;
                chk_noack         = 1'b1;
                repeat (stall_len) step();
                bus.c_respack[cl] = 1'b1;
                chk_noack         = 1'b0;
            end
            beat_q.push_back('{owner: (cl == 0) ? 2'b01 : 2'b10, data: base + 64'(i), tag: tag});
            step();
        end
        // Turnaround cycle: IDLE, and a late beat must not be acked
        bus.m_respcyc = 1'b1;
        bus.m_resp    = 64'hDEAD_BEEF;
        chk_idle      = 1'b1;
        step();
        chk_idle      = 1'b0;
        bus.m_respcyc = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.c_reqcyc  = 2'b00;
        bus.c_req     = '0;
        bus.c_reqtag  = '0;
        bus.c_respack = 2'b11;
        bus.m_reqack  = 1'b0;
        bus.m_respcyc = 1'b0;
        bus.m_resp    = '0;
        bus.m_resptag = '0;
        repeat (2) step();

        // Reset state, with a spurious memory beat present
        bus.m_respcyc = 1'b1;
        chk_idle      = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_idle      = 1'b0;
        bus.m_respcyc = 1'b0;

        // Single client 0, memory acks after 3 cycles
        set_req(0, 64'h1000, 13'h05);
        step();
        run_txn(0, 64'h1000, 13'h05, 64'hA0, 3, -1, 0, -1, 2'b01);

        // Tie straight after reset: client 0 first, then client 1
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 64'h2000, 13'h11);
        set_req(1, 64'h3000, 13'h12);
        step();
        run_txn(0, 64'h2000, 13'h11, 64'hB0, 1, -1, 0, -1, 2'b01);
        run_txn(1, 64'h3000, 13'h12, 64'hC0, 0, -1, 0, -1, 2'b10);

        // Continuous contention: grants alternate 0,1,0,1
        set_req(0, 64'h4000, 13'h21);
        set_req(1, 64'h5000, 13'h22);
        step();
        run_txn(0, 64'h4000, 13'h21, 64'hD0, 1, -1, 0, -1, 2'b00);
        run_txn(1, 64'h5000, 13'h22, 64'hE0, 2, -1, 0, -1, 2'b00);
        run_txn(0, 64'h4000, 13'h21, 64'hD8, 0, -1, 0, -1, 2'b00);
        run_txn(1, 64'h5000, 13'h22, 64'hE8, 1, -1, 0, -1, 2'b11);

        // Backpressure: client 1 withholds its ack for 2 cycles at beat 3
        set_req(1, 64'h6000, 13'h33);
        step();
        run_txn(1, 64'h6000, 13'h33, 64'hF0, 1, 3, 2, -1, 2'b10);

        // Reset at beat 5, then a fresh request from client 1
        set_req(0, 64'h7000, 13'h44);
        step();
        run_txn(0, 64'h7000, 13'h44, 64'h10, 1, -1, 0, 5, 2'b01);
        set_req(1, 64'h8000, 13'h55);
        step();
        run_txn(1, 64'h8000, 13'h55, 64'h20, 2, -1, 0, -1, 2'b10);

        repeat (2) step();
        done = 1'b1;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-client arbiter sharing the single Sysbus DRAM port between the instruction-side and data-side caches.
- Client 0 is the I-cache and client 1 is the D-cache. Each client issues one read request and receives a burst of BURST_BEATS response beats.
- The arbiter grants one client at a time using round-robin priority and holds the grant until the full burst has been acknowledged.
- It sits between the two cache instances and the memory-side bus.

Parameters:
- BUS_DATA_WIDTH, 64, width of address/request and response data.
- BUS_TAG_WIDTH, 13, width of request/response tag.
- BURST_BEATS, 8, response beats per transaction (one 512-bit line); must be ≥2.

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- c_reqcyc  input  2  per-client request valid; bit i = client i.
- c_reqack  output  2  per-client request acknowledge.
- c_req  input  2*BUS_DATA_WIDTH  per-client request address; client i in slice [i*W +: W].
- c_reqtag  input  2*BUS_TAG_WIDTH  per-client request tag, same slicing.
- c_respcyc  output  2  per-client response valid.
- c_respack  input  2  per-client response acknowledge.
- c_resp  output  BUS_DATA_WIDTH  response data, shared by both clients.
- c_resptag  output  BUS_TAG_WIDTH  response tag, shared by both clients.
- m_reqcyc  output  1  memory request valid.
- m_reqack  input  1  memory request acknowledge.
- m_req  output  BUS_DATA_WIDTH  memory request address.
- m_reqtag  output  BUS_TAG_WIDTH  memory request tag.
- m_respcyc  input  1  memory response valid.
- m_respack  output  1  memory response acknowledge.
- m_resp  input  BUS_DATA_WIDTH  memory response data.
- m_resptag  input  BUS_TAG_WIDTH  memory response tag.

Behaviour:
- Interface rule: reset is synchronous and active-high; clock is clk, rising edge. Reset is also the only abort mechanism.
- Registered state:
  - state ∈ {IDLE, REQ, RESP};
  - grant (1 bit);
  - last_grant (1 bit);
  - addr_q, tag_q;
  - beat counter, width $clog2(BURST_BEATS).
- Reset values:
  - state=IDLE, grant=0, last_grant=1 (so client 0 wins the first tie), beat=0, addr_q=0, tag_q=0.
  - All outputs 0: c_reqack, c_respcyc, m_reqcyc, m_req, m_reqtag, m_respack.
- Reset mid-REQ or mid-RESP: the transaction is abandoned and the arbiter returns to IDLE next cycle. Beats still arriving from memory are not acked.
- IDLE:
  - All request/response outputs are 0.
  - If exactly one c_reqcyc bit is set, that client wins. If both are set, the client != last_grant wins.
  - On a win: latch grant, addr_q = c_req slice, tag_q = c_reqtag slice; next state REQ.
  - If no request, stay in IDLE.
- REQ:
  - Drive m_reqcyc=1, m_req=addr_q, m_reqtag=tag_q (registered, stable for the whole state).
  - While m_reqack=0, stay in REQ.
  - In the cycle m_reqack=1, c_reqack[grant]=1 for exactly that cycle (combinational pass-through). Next state RESP, beat=0.
  - The client must hold c_reqcyc until it sees c_reqack; if it drops early, the latched request still completes.
- RESP:
  - c_resp=m_resp and c_resptag=m_resptag, combinational.
  - c_respcyc[grant]=m_respcyc; c_respcyc[~grant]=0.
  - m_respack = m_respcyc & c_respack[grant]. c_respack of the non-granted client is ignored.
  - On each beat where m_respcyc & m_respack: beat<=beat+1.
  - On the beat where beat==BURST_BEATS-1: next state IDLE, last_grant<=grant, beat<=0.
  - m_respcyc with no client ack is a stall: no count, stay in RESP.
- m_respcyc in IDLE or REQ is ignored (m_respack=0).
- Latency:
  - c_reqcyc in IDLE → m_reqcyc the next cycle.
  - m_reqack → c_reqack in the same cycle.
  - After the final beat there is one IDLE turnaround cycle before the next arbitration. A request arriving during the last beat is evaluated in that IDLE cycle.
- Fairness: with both clients requesting continuously, grants alternate 0,1,0,1,… No client waits more than one full transaction.
- The non-granted client's request is not acked and its inputs are not sampled; it must keep requesting.

Test Plan:
- Single client: reset; client 0 requests addr 0x1000, tag 0x05; memory acks after 3 cycles and returns beats 0xA0..0xA7 → m_req=0x1000, m_reqtag=0x05, c_reqack[0] pulses once, client 0 receives 8 beats in order, c_respcyc[1] stays 0, state returns to IDLE.
- Tie after reset: both clients request (0x2000 / 0x3000) → client 0 is served first; client 1 is granted in the cycle after the IDLE turnaround and m_req=0x3000.
- Continuous contention over 4 transactions → grant order 0,1,0,1. No overlap of c_respcyc bits and no extra beats.
- Backpressure: client deasserts c_respack for 2 cycles mid-burst (at beat 3) → m_respack=0 during those cycles, beat count holds at 3, and the burst still ends after exactly 8 acked beats.
- Spurious response: m_respcyc=1 while in IDLE and while in REQ → m_respack=0 and c_respcyc=0.
- Reset at beat 5 of a burst → the next cycle is IDLE with all outputs 0. A fresh request from client 1 is then granted (last_grant=1 after reset, so client 0 would win a tie).
